// File: rtl/lm07_pkg.sv
// Shared types and constants for the LM07 SPI temperature reader.
// LM07_AVG_EN (see lm07_spi_reader) selects the averaged temp_c output.
package lm07_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } lm07_state_e;

  localparam int NBITS_DEF = 16;
  localparam int WORD_W    = 16;
  localparam int TEMP_MSB  = 15;
  localparam int TEMP_LSB  = 7;
  localparam int TEMP_W    = 9;
  localparam int AVG_SUM_W = 11;

  // Whole-degree Celsius field of a sensor word (two's complement, 1 degC/LSB).
  function automatic logic [TEMP_W-1:0] temp_field(input logic [WORD_W-1:0] word);
    return word[TEMP_MSB:TEMP_LSB];
  endfunction

endpackage

// File: rtl/lm07_avg4.sv
// Four-tap running mean of signed temperature samples, floor-rounded.
// The first sample after reset primes every tap so the mean starts at that value.
module lm07_avg4
  import lm07_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TEMP_W-1:0] sample,
  output logic [TEMP_W-1:0] mean
);

  logic [TEMP_W-1:0]    hist [4];
  logic [TEMP_W-1:0]    hist_next [4];
  logic                 primed;
  logic [AVG_SUM_W-1:0] sum_next;

  // Next tap contents and their sign-extended sum.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hist_next[i] = sample;
    end
    if (primed) begin
      hist_next[1] = hist[0];
      hist_next[2] = hist[1];
      hist_next[3] = hist[2];
    end else begin
      hist_next[1] = sample;
      hist_next[2] = sample;
      hist_next[3] = sample;
    end
    sum_next = {AVG_SUM_W{1'b0}};
    for (int i = 0; i < 4; i++) begin
      sum_next = sum_next
               + {{(AVG_SUM_W - TEMP_W){hist_next[i][TEMP_W-1]}}, hist_next[i]};
    end
  end

  // Tap history and registered mean; bits [10:2] of the sum are an arithmetic >>2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        hist[i] <= {TEMP_W{1'b0}};
      end
      primed <= 1'b0;
      mean   <= {TEMP_W{1'b0}};
    end else if (load) begin
      for (int i = 0; i < 4; i++) begin
        hist[i] <= hist_next[i];
      end
      primed <= 1'b1;
      mean   <= sum_next[TEMP_W+1:2];
    end else begin
      primed <= primed;
      mean   <= mean;
    end
  end

endmodule

// File: rtl/lm07_spi_reader.sv
// SPI master that repeatedly reads an LM07 sensor word and reports raw and degC values.
// Define LM07_AVG_EN to report temp_c as the mean of the last four readings.
module lm07_spi_reader
  import lm07_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int NBITS    = NBITS_DEF,
  parameter int CONV_GAP = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              spi_sio,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic [WORD_W-1:0] data_raw,
  output logic [TEMP_W-1:0] temp_c,
  output logic              data_valid,
  output logic              busy
);

  localparam int DIV_W = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int GAP_W = (CONV_GAP > 1) ? $clog2(CONV_GAP) : 1;
  localparam int BIT_W = (NBITS    > 1) ? $clog2(NBITS)    : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CONV_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  lm07_state_e       state;
  logic [DIV_W-1:0]  div_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic              div_last;
  logic              gap_last;
  logic              frame_end;
  logic [TEMP_W-1:0] temp_now;

  // Terminal-count decodes shared by the FSM and the optional filter.
  always_comb begin
    div_last  = (div_cnt == DIV_LAST);
    gap_last  = (gap_cnt == GAP_LAST);
    frame_end = (state == SHIFT) && spi_sck && div_last && (bit_cnt == BIT_LAST);
    temp_now  = temp_field(shreg);
  end

  // Frame sequencer: CS/SCK generation, bit capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_raw   <= {WORD_W{1'b0}};
`ifndef LM07_AVG_EN
      temp_c     <= {TEMP_W{1'b0}};
`endif
      shreg      <= {WORD_W{1'b0}};
      div_cnt    <= {DIV_W{1'b0}};
      gap_cnt    <= {GAP_W{1'b0}};
      bit_cnt    <= {BIT_W{1'b0}};
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          spi_sck <= 1'b0;
          div_cnt <= {DIV_W{1'b0}};
          if (run) begin
            state    <= SETUP;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
          end else begin
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
          end
        end

        SETUP: begin
          if (div_last) begin
            state   <= SHIFT;
            div_cnt <= {DIV_W{1'b0}};
            bit_cnt <= {BIT_W{1'b0}};
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        // spi_sck itself marks which half of the bit period is running.
        SHIFT: begin
          if (!div_last) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= {DIV_W{1'b0}};
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              shreg   <= {shreg[WORD_W-2:0], spi_sio};
            end else begin
              spi_sck <= 1'b0;
              if (frame_end) begin
                state      <= DONE;
                spi_cs_n   <= 1'b1;
                data_valid <= 1'b1;
                data_raw   <= shreg;
`ifndef LM07_AVG_EN
                temp_c     <= temp_now;
`endif
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
        end

        DONE: begin
          state   <= GAP;
          busy    <= 1'b0;
          gap_cnt <= {GAP_W{1'b0}};
        end

        // The gap hands straight to SETUP when run is still high, so no idle cycle is lost.
        GAP: begin
          if (gap_last) begin
            gap_cnt <= {GAP_W{1'b0}};
            div_cnt <= {DIV_W{1'b0}};
            if (run) begin
              state    <= SETUP;
              spi_cs_n <= 1'b0;
              busy     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          spi_cs_n <= 1'b1;
          spi_sck  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef LM07_AVG_EN
  lm07_avg4 u_avg4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (frame_end),
    .sample (temp_now),
    .mean   (temp_c)
  );
`endif

endmodule

// File: tb/tb_lm07_spi_reader.sv
// Self-checking bench for lm07_spi_reader with a behavioural LM07 sensor,
// a protocol monitor and a degC reference model (averaged when LM07_AVG_EN is set).
module tb_lm07_spi_reader;

  localparam int CLK_DIV  = 4;
  localparam int NBITS    = 16;
  localparam int CONV_GAP = 64;
  localparam int LAT      = (1 + 2 * NBITS) * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        spi_sio;
  logic        spi_cs_n;
  logic        spi_sck;
  logic [15:0] data_raw;
  logic [8:0]  temp_c;
  logic        data_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] sensor_word = 16'h0000;
  logic [15:0] frame_word  = 16'h0000;
  int          bit_idx = -1;

  int   rise_cnt = 0;
  int   last_rise = -1;
  int   cs_fall_cnt = 0;
  logic prev_cs = 1'b1;
  logic prev_sck = 1'b0;
  int   avg_q[$];

  typedef struct {
    logic [15:0] word;
    int          exp_temp;
    string       name;
  } vec_t;
  vec_t vecs[8];

  lm07_spi_reader #(.CLK_DIV(CLK_DIV), .NBITS(NBITS), .CONV_GAP(CONV_GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .spi_sio    (spi_sio),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .data_raw   (data_raw),
    .temp_c     (temp_c),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor: presents the MSB when selected, moves to the next bit on each SCK fall.
  always @(negedge spi_cs_n) begin
    frame_word = sensor_word;
    bit_idx    = NBITS - 1;
  end
  always @(negedge spi_sck) begin
    if (!spi_cs_n && bit_idx > 0) bit_idx = bit_idx - 1;
  end
  assign spi_sio = (bit_idx >= 0 && bit_idx < NBITS) ? frame_word[bit_idx] : 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Protocol monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("sck_low_when_deselected", (spi_cs_n && spi_sck) ? 1 : 0, 0);
      if (spi_sck) check("cs_stable_while_sck_high", spi_cs_n, prev_cs);
      if (spi_sck && !prev_sck) begin
        rise_cnt++;
        if (last_rise >= 0) check("sck_period", cyc - last_rise, 2 * CLK_DIV);
        last_rise = cyc;
      end
      if (!spi_cs_n && prev_cs) begin
        rise_cnt  = 0;
        last_rise = -1;
        cs_fall_cnt++;
      end
      if (spi_cs_n && !prev_cs) check("sck_rises_per_frame", rise_cnt, NBITS);
    end else begin
      rise_cnt  = 0;
      last_rise = -1;
    end
    prev_cs  = spi_cs_n;
    prev_sck = spi_sck;
  end

  // Reference: degC is floor(signed word / 128).
  function automatic int floor_temp(input logic [15:0] w);
    int ws;
    ws = int'($signed(w));
    return ws >>> 7;
  endfunction

  // Reference: mean of the last four readings, first reading fills the history.
  function automatic int avg_apply(input int raw);
`ifdef LM07_AVG_EN
    int s;
    if (avg_q.size() == 0) begin
      repeat (4) avg_q.push_back(raw);
    end else begin
      void'(avg_q.pop_front());
      avg_q.push_back(raw);
    end
    s = 0;
    foreach (avg_q[i]) s += avg_q[i];
    return s >>> 2;
`else
    return raw;
`endif
  endfunction

  task automatic wait_cs_low(output int t, output bit ok, input int bound, input string nm);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!spi_cs_n) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_cs_timeout: cs_n still high after %0d cycles, expected low", nm, bound);
    end
  endtask

  task automatic wait_valid(output int t, output bit ok, input int bound, input string nm);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (data_valid) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_valid_timeout: no data_valid in %0d cycles, expected a pulse", nm, bound);
    end
  endtask

  task automatic check_result(input string nm, input logic [15:0] w, input int exp_t);
    check({nm, "_raw"}, data_raw, w);
    check({nm, "_temp"}, int'($signed(temp_c)), exp_t);
    check({nm, "_busy_done"}, busy, 1);
  endtask

  // One frame with run dropped right after CS falls.
  task automatic run_frame(input logic [15:0] w, input int exp_t, input string nm);
    int t0, t1;
    bit ok;
    sensor_word = w;
    run = 1'b1;
    wait_cs_low(t0, ok, 300, nm);
    run = 1'b0;
    if (ok) begin
      wait_valid(t1, ok, LAT + 50, nm);
      if (ok) begin
        check({nm, "_latency"}, t1 - t0, LAT);
        check_result(nm, w, exp_t);
        @(negedge clk);
        check({nm, "_valid_one_cycle"}, data_valid, 0);
        check({nm, "_raw_hold"}, data_raw, w);
        check({nm, "_busy_gap"}, busy, 0);
      end
    end
  endtask

  initial begin
    int  t0, t1, t2, t3, exp_t, falls, pulses;
    bit  ok;

    vecs[0] = '{16'h0B9F, 23, "t23"};
    vecs[1] = '{16'h191F, 50, "t50"};
    vecs[2] = '{16'hF39F, -25, "tneg25"};
    for (int i = 3; i < 8; i++) begin
      vecs[i].word     = 16'($urandom);
      vecs[i].exp_temp = floor_temp(vecs[i].word);
      vecs[i].name     = $sformatf("rand%0d", i);
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_raw", data_raw, 0);
    check("rst_temp", temp_c, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_cs_n", spi_cs_n, 1);

    for (int i = 0; i < 8; i++) begin
      exp_t = avg_apply(vecs[i].exp_temp);
      run_frame(vecs[i].word, exp_t, vecs[i].name);
    end

    // Continuous run: gap between frames, then run dropped mid-SHIFT.
    sensor_word = 16'h191F;
    run = 1'b1;
    wait_cs_low(t0, ok, 300, "cont1");
    if (ok) wait_valid(t1, ok, LAT + 50, "cont1");
    if (ok) begin
      check("cont1_latency", t1 - t0, LAT);
      check_result("cont1", 16'h191F, avg_apply(floor_temp(16'h191F)));
      wait_cs_low(t2, ok, CONV_GAP + 20, "cont2");
      if (ok) begin
        check("cont_gap", t2 - t1, CONV_GAP + 1);
        repeat (CLK_DIV + 6 * CLK_DIV) @(negedge clk);
        run = 1'b0;
        wait_valid(t3, ok, LAT + 50, "cont2");
        if (ok) begin
          check("cont2_latency", t3 - t2, LAT);
          check_result("cont2", 16'h191F, avg_apply(floor_temp(16'h191F)));
          falls  = cs_fall_cnt;
          pulses = 0;
          repeat (200) begin
            @(negedge clk);
            if (data_valid) pulses++;
          end
          check("stop_no_cs_activity", cs_fall_cnt - falls, 0);
          check("stop_no_valid", pulses, 0);
          check("stop_busy", busy, 0);
        end
      end
    end
    run = 1'b0;

    // Reset during bit 8 of SHIFT.
    sensor_word = 16'h5A5A;
    run = 1'b1;
    wait_cs_low(t0, ok, 300, "abort");
    if (ok) begin
      repeat (CLK_DIV + 16 * CLK_DIV) @(negedge clk);
      check("abort_rises_before_reset", rise_cnt, 8);
      rst_n = 1'b0;
      run   = 1'b0;
      @(negedge clk);
      check("abort_cs_n", spi_cs_n, 1);
      check("abort_sck", spi_sck, 0);
      check("abort_raw", data_raw, 0);
      check("abort_temp", temp_c, 0);
      check("abort_valid", data_valid, 0);
      check("abort_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      avg_q.delete();
      pulses = 0;
      falls  = cs_fall_cnt;
      repeat (LAT + 20) begin
        @(negedge clk);
        if (data_valid) pulses++;
      end
      check("abort_no_valid", pulses, 0);
      check("abort_no_new_frame", cs_fall_cnt - falls, 0);
      run_frame(16'h0B9F, avg_apply(23), "after_abort");
    end

`ifdef LM07_AVG_EN
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    avg_q.delete();
    run_frame(16'h0B9F, 23, "avg1");
    run_frame(16'h191F, 29, "avg2");
    run_frame(16'h191F, 36, "avg3");
    run_frame(16'h191F, 43, "avg4");
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
